// File: rtl/filtro_canal_scheduler.sv
// ---------------------------------------------------------------------------
// filtro_canal_scheduler
//   Round-robin scheduler sharing one filter MAC datapath (coefficient ROM,
//   function mux, accumulator) between N_CH sample channels. One requesting
//   channel is granted at a time. Its job runs for N_TAPS tap cycles, then a
//   single DONE cycle pulses ack back to that channel.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high
//   req         per-channel sample ready (level, held until ack)
//   gnt         one-hot grant, held from tap 0 through DONE
//   ack         one-cycle pulse to the served channel at job end
//   ch_sel      index of the granted channel (datapath state mux)
//   sel_const   coefficient index = current tap
//   sel_fun     00 idle, 01 load sample (tap 0), 10 MAC (taps >= 1)
//   sel_acum    00 hold, 01 load (tap 0), 10 accumulate (taps >= 1)
//   sh_r        delay-line shift strobe, high at tap SHIFT_TAP only
//   band_listo  job complete, high in the DONE cycle
//   busy        high in RUN and DONE
//
// Every output is a flop. The next-state logic computes next-cycle output
// values alongside the next state, so outputs change cleanly on clk.
// ---------------------------------------------------------------------------
module filtro_canal_scheduler #(
  parameter int N_CH      = 2,
  parameter int CH_W      = 1,
  parameter int N_TAPS    = 5,
  parameter int SHIFT_TAP = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   req,
  output logic [N_CH-1:0]   gnt,
  output logic [N_CH-1:0]   ack,
  output logic [CH_W-1:0]   ch_sel,
  output logic [2:0]        sel_const,
  output logic [1:0]        sel_fun,
  output logic [1:0]        sel_acum,
  output logic              sh_r,
  output logic              band_listo,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [2:0]      LAST_TAP = 3'(N_TAPS - 1);
  localparam logic [2:0]      SH_TAP   = 3'(SHIFT_TAP);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(N_CH - 1);
  localparam logic [CH_W:0]   N_CH_X   = (CH_W + 1)'(N_CH);

  state_t          state, state_n;
  logic [2:0]      tap, tap_n;
  logic [CH_W-1:0] ptr, ptr_n;
  logic [CH_W-1:0] winner, winner_n;

  logic [N_CH-1:0] gnt_n, ack_n;
  logic [CH_W-1:0] ch_sel_n;
  logic [2:0]      sel_const_n;
  logic [1:0]      sel_fun_n, sel_acum_n;
  logic            sh_r_n, band_listo_n, busy_n;

  // Round-robin search: first set request starting at ptr, wrapping at N_CH
  // by explicit compare so non-power-of-2 channel counts wrap correctly.
  logic [2**CH_W-1:0] req_pad;
  logic               found;
  logic [CH_W-1:0]    pick;
  logic [CH_W:0]      sum;

  always_comb begin
    req_pad            = '0;
    req_pad[N_CH-1:0]  = req;
    found              = 1'b0;
    pick               = '0;
    sum                = '0;
    for (int k = 0; k < N_CH; k++) begin
      sum = {1'b0, ptr} + (CH_W + 1)'(k);
      if (sum >= N_CH_X) sum = sum - N_CH_X;
      if (!found && req_pad[sum[CH_W-1:0]]) begin
        found = 1'b1;
        pick  = sum[CH_W-1:0];
      end
    end
  end

  // Next state and next-cycle output values.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can leave one unassigned and infer a latch.
    state_n      = state;
    tap_n        = tap;
    ptr_n        = ptr;
    winner_n     = winner;
    gnt_n        = '0;
    ack_n        = '0;
    ch_sel_n     = '0;
    sel_const_n  = '0;
    sel_fun_n    = 2'b00;
    sel_acum_n   = 2'b00;
    sh_r_n       = 1'b0;
    band_listo_n = 1'b0;
    busy_n       = 1'b0;

    case (state)
      IDLE: begin
        if (found) begin
          state_n     = RUN;
          tap_n       = '0;
          winner_n    = pick;
          gnt_n       = N_CH'(1) << pick;
          ch_sel_n    = pick;
          sel_fun_n   = 2'b01;
          sel_acum_n  = 2'b01;
          sh_r_n      = (SH_TAP == 3'd0);
          busy_n      = 1'b1;
        end
      end

      RUN: begin
        gnt_n    = N_CH'(1) << winner;
        ch_sel_n = winner;
        busy_n   = 1'b1;
        if (tap == LAST_TAP) begin
          // Entering DONE: accumulator holds, result is handed back.
          state_n      = DONE;
          ack_n        = N_CH'(1) << winner;
          band_listo_n = 1'b1;
        end else begin
          tap_n       = tap + 3'd1;
          sel_const_n = tap + 3'd1;
          sel_fun_n   = 2'b10;
          sel_acum_n  = 2'b10;
          sh_r_n      = ((tap + 3'd1) == SH_TAP);
        end
      end

      DONE: begin
        state_n = IDLE;
        ptr_n   = (winner == LAST_CH) ? '0 : winner + CH_W'(1);
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tap        <= '0;
      ptr        <= '0;
      winner     <= '0;
      gnt        <= '0;
      ack        <= '0;
      ch_sel     <= '0;
      sel_const  <= '0;
      sel_fun    <= 2'b00;
      sel_acum   <= 2'b00;
      sh_r       <= 1'b0;
      band_listo <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state      <= state_n;
      tap        <= tap_n;
      ptr        <= ptr_n;
      winner     <= winner_n;
      gnt        <= gnt_n;
      ack        <= ack_n;
      ch_sel     <= ch_sel_n;
      sel_const  <= sel_const_n;
      sel_fun    <= sel_fun_n;
      sel_acum   <= sel_acum_n;
      sh_r       <= sh_r_n;
      band_listo <= band_listo_n;
      busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_filtro_canal_scheduler.sv
// ---------------------------------------------------------------------------
// tb_filtro_canal_scheduler
//   Directed bench for filtro_canal_scheduler. Inputs change and outputs are
//   sampled on the falling edge. "Cycle k" is the state after the k-th rising
//   edge following the cycle in which req is first presented (cycle 0).
// ---------------------------------------------------------------------------
module tb_filtro_canal_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [1:0] gnt, ack;
  logic       ch_sel;
  logic [2:0] sel_const;
  logic [1:0] sel_fun, sel_acum;
  logic       sh_r, band_listo, busy;

  logic [3:0] req4;
  logic [3:0] gnt4, ack4;
  logic [1:0] ch_sel4;
  logic [2:0] sel_const4;
  logic [1:0] sel_fun4, sel_acum4;
  logic       sh_r4, band_listo4, busy4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  filtro_canal_scheduler #(.N_CH(2), .CH_W(1), .N_TAPS(5), .SHIFT_TAP(1)) dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt), .ack(ack), .ch_sel(ch_sel),
    .sel_const(sel_const), .sel_fun(sel_fun), .sel_acum(sel_acum), .sh_r(sh_r),
    .band_listo(band_listo), .busy(busy)
  );

  filtro_canal_scheduler #(.N_CH(4), .CH_W(2), .N_TAPS(5), .SHIFT_TAP(1)) dut4 (
    .clk(clk), .reset(reset), .req(req4), .gnt(gnt4), .ack(ack4), .ch_sel(ch_sel4),
    .sel_const(sel_const4), .sel_fun(sel_fun4), .sel_acum(sel_acum4), .sh_r(sh_r4),
    .band_listo(band_listo4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " gnt"},  32'(gnt),  32'd0);
    check({tag, " ack"},  32'(ack),  32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " fun"},  32'(sel_fun),  32'd0);
    check({tag, " acum"}, 32'(sel_acum), 32'd0);
    check({tag, " sh_r"}, 32'(sh_r), 32'd0);
  endtask

  // Two-cycle reset; leaves the bench at a falling edge ready for cycle 0.
  task automatic do_reset();
    reset = 1'b1;
    req   = 2'b00;
    req4  = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Checks cycles 1..6 of one job for channel ch. The served request is
  // dropped on the ack cycle unless hold is set, or earlier at cycle drop_at.
  task automatic check_job(input string tn, input int ch, input bit hold, input int drop_at);
    logic [1:0] eg;
    string      t;
    eg = 2'b01 << ch;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      t = $sformatf("%s ch%0d c%0d", tn, ch, k);
      check({t, " gnt"},    32'(gnt),    32'(eg));
      check({t, " ch_sel"}, 32'(ch_sel), 32'(ch));
      check({t, " busy"},   32'(busy),   32'd1);
      if (k <= 5) begin
        check({t, " const"}, 32'(sel_const), 32'(k - 1));
        check({t, " fun"},   32'(sel_fun),   (k == 1) ? 32'd1 : 32'd2);
        check({t, " acum"},  32'(sel_acum),  (k == 1) ? 32'd1 : 32'd2);
        check({t, " sh_r"},  32'(sh_r),      (k == 2) ? 32'd1 : 32'd0);
        check({t, " ack"},   32'(ack),       32'd0);
        check({t, " band"},  32'(band_listo), 32'd0);
      end else begin
        check({t, " const"}, 32'(sel_const), 32'd0);
        check({t, " fun"},   32'(sel_fun),   32'd0);
        check({t, " acum"},  32'(sel_acum),  32'd0);
        check({t, " sh_r"},  32'(sh_r),      32'd0);
        check({t, " ack"},   32'(ack),       32'(eg));
        check({t, " band"},  32'(band_listo), 32'd1);
      end
      if (k == drop_at || (k == 6 && !hold)) req[ch] = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_ch [3] = '{1, 3, 1};
    int w;

    // Reset state
    do_reset();
    check_idle("reset");
    check("reset band",   32'(band_listo), 32'd0);
    check("reset const",  32'(sel_const),  32'd0);
    check("reset gnt4",   32'(gnt4),       32'd0);

    // 1) single request on ch0
    req = 2'b01;
    check_job("t1", 0, 1'b0, 0);
    @(negedge clk);
    check_idle("t1 c7");

    // 2) both requesting; ch0 first, then ch1 after one IDLE cycle
    do_reset();
    req = 2'b11;
    check_job("t2", 0, 1'b0, 0);
    @(negedge clk);
    check_idle("t2 c7");
    check_job("t2", 1, 1'b0, 0);
    @(negedge clk);
    check_idle("t2 c14");

    // 3) continuous requests: alternating grants 0,1,0,1,0,1
    do_reset();
    req = 2'b11;
    for (int j = 0; j < 6; j++) begin
      check_job($sformatf("t3 j%0d", j), j % 2, 1'b1, 0);
      @(negedge clk);
      check($sformatf("t3 j%0d idle busy", j), 32'(busy), 32'd0);
    end
    req = 2'b00;

    // 4) reset at tap 2 of a ch0 job, then ch1 request served
    do_reset();
    req = 2'b01;
    repeat (3) @(negedge clk);
    check("t4 at tap2", 32'(sel_const), 32'd2);
    reset = 1'b1;
    req   = 2'b00;
    @(negedge clk);
    check_idle("t4 post-reset");
    check("t4 post-reset const", 32'(sel_const), 32'd0);
    reset = 1'b0;
    req   = 2'b10;
    check_job("t4", 1, 1'b0, 0);

    // 5) req dropped at tap 1; job still completes, no new grant afterwards
    do_reset();
    req = 2'b01;
    check_job("t5", 0, 1'b0, 2);
    @(negedge clk);
    check_idle("t5 c7");
    @(negedge clk);
    check_idle("t5 c8");

    // 6) four channels, req=1010 held: ch1, ch3, then wrap to ch1
    do_reset();
    req4 = 4'b1010;
    for (int j = 0; j < 3; j++) begin
      w = 0;
      while (ack4 == 4'b0000 && w < 20) begin
        @(negedge clk);
        w++;
      end
      check($sformatf("t6 j%0d ack timeout", j), 32'(w < 20), 32'd1);
      check($sformatf("t6 j%0d ack", j),    32'(ack4),    32'(4'b0001 << exp_ch[j]));
      check($sformatf("t6 j%0d gnt", j),    32'(gnt4),    32'(4'b0001 << exp_ch[j]));
      check($sformatf("t6 j%0d ch_sel", j), 32'(ch_sel4), 32'(exp_ch[j]));
      check($sformatf("t6 j%0d band", j),   32'(band_listo4), 32'd1);
      @(negedge clk);
    end
    req4 = 4'b0000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
